// File: rtl/tennis_pkg.sv
// Shared types and helpers for the LED tennis game engine.
package tennis_pkg;

    typedef enum logic [2:0] {
        SERVE,
        MOVE_R,
        MOVE_L,
        POINT,
        GAME_OVER
    } state_t;

    localparam logic PLAYER_L = 1'b0;
    localparam logic PLAYER_R = 1'b1;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_L    = 2'b01;
    localparam logic [1:0] WINNER_R    = 2'b10;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/tennis_tick_gen.sv
// Ball-step timebase: one-cycle tick every TICK_DIV clocks,
// restarted by clr so each state sees a full first period.
module tennis_tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tennis_rally_ctrl.sv
// Tennis game engine: ball movement, hit judging, scoring and
// game-over display. All outputs are registered.
module tennis_rally_ctrl
    import tennis_pkg::*;
#(
    parameter int NUM_LEDS    = 16,
    parameter int TICK_DIV    = 10_000_000,
    parameter int POINT_TICKS = 4,
    parameter int WIN_SCORE   = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hit_l,
    input  logic                hit_r,
    output logic [NUM_LEDS-1:0] leds,
    output logic [3:0]          score_l,
    output logic [3:0]          score_r,
    output logic [1:0]          winner
);

    localparam int PW  = $clog2(NUM_LEDS);
    localparam int PTW = (POINT_TICKS > 1) ? $clog2(POINT_TICKS) : 1;

    localparam logic [PW-1:0]  POS_L   = PW'(NUM_LEDS - 1);
    localparam logic [PTW-1:0] PT_LAST = PTW'(POINT_TICKS - 1);

    localparam logic [NUM_LEDS-1:0] HALF_HI =
        {{(NUM_LEDS/2){1'b1}}, {(NUM_LEDS-NUM_LEDS/2){1'b0}}};
    localparam logic [NUM_LEDS-1:0] HALF_LO =
        {{(NUM_LEDS-NUM_LEDS/2){1'b0}}, {(NUM_LEDS/2){1'b1}}};

    state_t         state, state_n;
    logic           server, server_n;
    logic [PW-1:0]  pos, pos_n;
    logic [PTW-1:0] pt_cnt, pt_cnt_n;
    logic [NUM_LEDS-1:0] leds_n;
    logic [3:0]     score_l_n, score_r_n;
    logic [1:0]     winner_n;
    logic           tick;
    logic           clr;
    logic           award;
    logic           scorer;

    function automatic logic [PW-1:0] end_pos(input logic p);
        return (p == PLAYER_L) ? POS_L : '0;
    endfunction

    tennis_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    assign clr = (state_n != state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SERVE;
            server  <= PLAYER_L;
            pos     <= POS_L;
            pt_cnt  <= '0;
            leds    <= NUM_LEDS'(1) << (NUM_LEDS - 1);
            score_l <= '0;
            score_r <= '0;
            winner  <= WINNER_NONE;
        end else begin
            state   <= state_n;
            server  <= server_n;
            pos     <= pos_n;
            pt_cnt  <= pt_cnt_n;
            leds    <= leds_n;
            score_l <= score_l_n;
            score_r <= score_r_n;
            winner  <= winner_n;
        end
    end

    always_comb begin
        state_n   = state;
        server_n  = server;
        pos_n     = pos;
        pt_cnt_n  = pt_cnt;
        leds_n    = leds;
        score_l_n = score_l;
        score_r_n = score_r;
        winner_n  = winner;
        award     = 1'b0;
        scorer    = PLAYER_L;

        unique case (state)
            SERVE: begin
                if (server == PLAYER_L && hit_l) begin
                    state_n = MOVE_R;
                end else if (server == PLAYER_R && hit_r) begin
                    state_n = MOVE_L;
                end
            end
            MOVE_R: begin
                // A hit outranks a same-cycle tick, both for returns and faults
                if (hit_r) begin
                    if (pos == '0) begin
                        state_n = MOVE_L;
                    end else begin
                        award  = 1'b1;
                        scorer = PLAYER_L;
                    end
                end else if (tick) begin
                    if (pos == '0) begin
                        award  = 1'b1;
                        scorer = PLAYER_L;
                    end else begin
                        pos_n = pos - PW'(1);
                    end
                end
            end
            MOVE_L: begin
                if (hit_l) begin
                    if (pos == POS_L) begin
                        state_n = MOVE_R;
                    end else begin
                        award  = 1'b1;
                        scorer = PLAYER_R;
                    end
                end else if (tick) begin
                    if (pos == POS_L) begin
                        award  = 1'b1;
                        scorer = PLAYER_R;
                    end else begin
                        pos_n = pos + PW'(1);
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    if (pt_cnt == PT_LAST) begin
                        pt_cnt_n = '0;
                        if (score_l >= 4'(WIN_SCORE)) begin
                            state_n  = GAME_OVER;
                            winner_n = WINNER_L;
                            leds_n   = HALF_HI;
                        end else if (score_r >= 4'(WIN_SCORE)) begin
                            state_n  = GAME_OVER;
                            winner_n = WINNER_R;
                            leds_n   = HALF_LO;
                        end else begin
                            state_n = SERVE;
                            pos_n   = end_pos(server);
                        end
                    end else begin
                        pt_cnt_n = pt_cnt + PTW'(1);
                    end
                end
            end
            GAME_OVER: begin
                if (hit_l || hit_r) begin
                    state_n   = SERVE;
                    server_n  = (winner == WINNER_L) ? PLAYER_R : PLAYER_L;
                    pos_n     = end_pos(server_n);
                    score_l_n = '0;
                    score_r_n = '0;
                    winner_n  = WINNER_NONE;
                end else if (tick) begin
                    if (leds == '0) begin
                        leds_n = (winner == WINNER_L) ? HALF_HI : HALF_LO;
                    end else begin
                        leds_n = '0;
                    end
                end
            end
            default: begin
                state_n = SERVE;
                pos_n   = end_pos(server);
            end
        endcase

        if (award) begin
            state_n  = POINT;
            server_n = scorer;
            pt_cnt_n = '0;
            if (scorer == PLAYER_L) begin
                score_l_n = sat_inc(score_l);
            end else begin
                score_r_n = sat_inc(score_r);
            end
        end

        unique case (state_n)
            SERVE, MOVE_R, MOVE_L: leds_n = NUM_LEDS'(1) << pos_n;
            POINT:                 leds_n = '1;
            default:               ;
        endcase
    end

endmodule

// File: tb/tb_tennis_rally_ctrl.sv
// Directed bench for tennis_rally_ctrl with a small, fast game setup.
module tb_tennis_rally_ctrl;

    logic       clk;
    logic       rst;
    logic       hit_l;
    logic       hit_r;
    logic [3:0] leds;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    tennis_rally_ctrl #(
        .NUM_LEDS   (4),
        .TICK_DIV   (4),
        .POINT_TICKS(2),
        .WIN_SCORE  (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .hit_l  (hit_l),
        .hit_r  (hit_r),
        .leds   (leds),
        .score_l(score_l),
        .score_r(score_r),
        .winner (winner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic l, input logic r);
        hit_l = l;
        hit_r = r;
        cyc(1);
        hit_l = 1'b0;
        hit_r = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        hit_l = 1'b0;
        hit_r = 1'b0;
        #12;
        check("rst_leds", leds, 4'b1000);
        check("rst_sl", score_l, 0);
        check("rst_sr", score_r, 0);
        check("rst_win", winner, 2'b00);
        rst = 1'b1;
        cyc(1);

        // clean rally
        pulse(1, 0);
        check("serve_l", leds, 4'b1000);
        cyc(4); check("mr_0100", leds, 4'b0100);
        cyc(4); check("mr_0010", leds, 4'b0010);
        cyc(4); check("mr_0001", leds, 4'b0001);
        pulse(0, 1);
        check("ret_r", leds, 4'b0001);
        cyc(4); check("ml_0010", leds, 4'b0010);
        cyc(4); check("ml_0100", leds, 4'b0100);
        cyc(4); check("ml_1000", leds, 4'b1000);
        check("rally_sl", score_l, 0);
        check("rally_sr", score_r, 0);

        // left returns, right misses
        pulse(1, 0);
        cyc(12); check("miss_pre", leds, 4'b0001);
        cyc(4);
        check("miss_sl", score_l, 1);
        check("miss_leds", leds, 4'b1111);
        cyc(7); check("point_hold", leds, 4'b1111);
        cyc(1); check("reserve", leds, 4'b1000);

        // non-server hit and ticks ignored in SERVE
        pulse(0, 1);
        cyc(4); check("serve_ign", leds, 4'b1000);

        // early fault ends the game; hit_l mid-rally ignored
        pulse(1, 0);
        cyc(1);
        pulse(1, 0);
        cyc(2); check("ign_hitl", leds, 4'b0100);
        pulse(0, 1);
        check("fault_sl", score_l, 2);
        check("fault_leds", leds, 4'b1111);
        cyc(7); check("pt_win0", winner, 2'b00);
        cyc(1);
        check("go_win", winner, 2'b01);
        check("go_on", leds, 4'b1100);
        cyc(4); check("go_off", leds, 4'b0000);
        cyc(4); check("go_on2", leds, 4'b1100);
        pulse(0, 1);
        check("go_clr_sl", score_l, 0);
        check("go_clr_w", winner, 2'b00);
        check("go_srv_r", leds, 4'b0001);

        // both hits in SERVE, right serving
        pulse(1, 1);
        cyc(4); check("both_srv", leds, 4'b0010);
        cyc(8); check("ml_end", leds, 4'b1000);

        // return coincident with tick
        cyc(3);
        pulse(1, 0);
        check("ret_tick", leds, 4'b1000);
        check("ret_tick_sr", score_r, 0);
        cyc(4); check("ret_tick_mv", leds, 4'b0100);

        // early hit coincident with tick
        cyc(3);
        pulse(0, 1);
        check("flt_tick", leds, 4'b1111);
        check("flt_tick_sl", score_l, 1);

        // async reset mid-POINT
        cyc(2);
        rst = 1'b0;
        #2;
        check("arst_leds", leds, 4'b1000);
        check("arst_sl", score_l, 0);
        check("arst_win", winner, 2'b00);
        rst = 1'b1;
        cyc(1);

        // both hits in SERVE, left serving
        pulse(1, 1);
        cyc(4); check("both_l", leds, 4'b0100);
        check("both_l_sr", score_r, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tennis_rally_ctrl.md
Name: tennis_rally_ctrl

Overview:
Game engine for the LED tennis game. It sits directly downstream of the two button debouncers and consumes their one-cycle clean pulses as hit_l and hit_r. It moves a one-hot ball across an LED row, judges hits, misses and early-hit faults, keeps both scores and declares a winner. LED and score outputs drive the display logic.

Parameters:
NUM_LEDS, 16, LED row length. Must be at least 3. pos[NUM_LEDS-1] is the left player's end; pos 0 is the right player's end.
TICK_DIV, 10_000_000, clk cycles per ball step (100 ms at 100 MHz). Must be at least 2.
POINT_TICKS, 4, ticks spent in the POINT display.
WIN_SCORE, 7, score that ends the game. Must be at most 15.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous, active-low reset (0 = reset).
hit_l  in  1  one-cycle debounced pulse from the left player.
hit_r  in  1  one-cycle debounced pulse from the right player.
leds  out  NUM_LEDS  LED pattern, registered.
score_l  out  4  left score, registered.
score_r  out  4  right score, registered.
winner  out  2  00 = none, 01 = left, 10 = right, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=SERVE, server=LEFT, pos=NUM_LEDS-1.
  - leds=1<<(NUM_LEDS-1), score_l=0, score_r=0, winner=00.
  - Tick counter=0, point-tick count=0.
- Tick: counter runs 0..TICK_DIV-1. tick=1 when the count equals TICK_DIV-1, then the counter wraps to 0.
  - The counter clears to 0 on every state change, so the first tick comes TICK_DIV cycles after entry to a state.
- Latency: an input pulse or tick in cycle N updates state and outputs at the edge ending cycle N. Outputs are visible in cycle N+1.
- SERVE:
  - leds = one-hot at the server's end.
  - The server's hit moves to MOVE_R (left serving) or MOVE_L (right serving).
  - The non-server's hit is ignored. Ticks are ignored.
- MOVE_R (ball travels toward pos 0; the receiver is RIGHT):
  - On tick with pos>0: pos decrements.
  - hit_r while pos==0: return. Go to MOVE_L; pos stays 0.
  - hit_r while pos>0: early-hit fault. Point to LEFT.
  - tick while pos==0 and no hit_r: miss. Point to LEFT.
  - hit_l is ignored.
- MOVE_L: mirror image of MOVE_R.
  - The receiver is LEFT, the end is pos==NUM_LEDS-1, and pos increments.
- Simultaneous events:
  - Valid return and tick in the same cycle: the return wins.
  - Early hit and tick in the same cycle: the fault wins.
  - hit_l and hit_r in the same cycle: each is judged by the rules above. Only the receiver's pulse (MOVE states) or the server's pulse (SERVE) has any effect.
- Point awarded:
  - The scorer's score increments (4-bit, saturates at 15).
  - server = scorer. State goes to POINT. leds = all ones.
- POINT:
  - Counts POINT_TICKS ticks; hits are ignored.
  - Then, if either score >= WIN_SCORE: go to GAME_OVER with winner set.
  - Otherwise go to SERVE with pos at the new server's end.
- GAME_OVER:
  - leds toggle on each tick between 0 and the winner's half: upper NUM_LEDS/2 bits for left, lower for right.
  - Any hit pulse clears both scores, sets winner=00, server = loser, and goes to SERVE.
- Reset mid-rally or mid-POINT: immediate return to the reset values, no partial update.
- leds is always one-hot in SERVE, MOVE_R and MOVE_L.

Decomposition:
- Package tennis_pkg holds:
  - state encoding: SERVE, MOVE_R, MOVE_L, POINT, GAME_OVER (3 bits);
  - PLAYER_L=1'b0, PLAYER_R=1'b1;
  - WINNER_NONE, WINNER_L, WINNER_R.
- One sub-module, tennis_tick_gen, with parameter TICK_DIV and ports clk, rst, clr, tick.
  - clr is a synchronous clear, pulsed by the FSM on every state change.

Test Plan:
All scenarios use bench parameters NUM_LEDS=4, TICK_DIV=4, POINT_TICKS=2, WIN_SCORE=2.
1. Clean rally: after reset, leds=1000. hit_l moves the ball to 0100, 0010, 0001 on successive ticks (every 4 cycles). hit_r at 0001 sends it back through 0010, 0100, 1000. No score change.
2. Miss: left serves, right never hits. The tick after leds=0001 gives score_l=1 and leds=1111 for 2 ticks, then SERVE with leds=1000.
3. Early fault: left serves, hit_r while leds=0100. Next cycle: score_l=1, leds=1111. A hit_l during the rally has no effect.
4. Simultaneous events: at leds=0001, hit_r and tick in the same cycle give a return (state MOVE_L, no point). hit_l and hit_r together in SERVE with server=LEFT start the rally.
5. Game over: the left player wins 2 points. After POINT: winner=01, and leds alternate 1100/0000 every 4 cycles. A following hit_r clears the scores to 0/0 and gives SERVE, server=RIGHT, leds=0001.
6. Reset: assert rst=0 mid-POINT with score_l=1. Outputs go to the reset values immediately, without waiting for clk.
